// File: rtl/playlist_pkg.sv
// Shared definitions for the playlist controller.
//   state_t      : controller FSM encoding (PAUSED / PLAYING / SWITCH)
//   MODE_*       : end-of-song policy codes carried on the 2-bit mode input
//   LFSR_TAPS    : feedback mask of the 8-bit right-shifting Galois LFSR
//   lfsr_next()  : one LFSR step; a nonzero state never maps to zero
package playlist_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SWITCH  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STOP       = 2'b00;
  localparam logic [1:0] MODE_REPEAT_ONE = 2'b01;
  localparam logic [1:0] MODE_REPEAT_ALL = 2'b10;
  localparam logic [1:0] MODE_SHUFFLE    = 2'b11;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/playlist_controller_lfsr.sv
// Free-running 8-bit Galois LFSR used as the shuffle entropy source.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset, loads SEED
//   q     : current LFSR state, advances every cycle while out of reset
// SEED must be nonzero, otherwise the register locks at zero.
module lfsr_galois8
  import playlist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/playlist_controller.sv
// Playlist sequencer between the one-pulsed buttons and the song reader /
// note player. Selects the current song, runs play/pause and emits a
// one-cycle reset_player pulse on every song switch.
// Ports:
//   clk, reset    : system clock, asynchronous active-low reset
//   play_button   : pulse, toggles play/pause
//   next_button   : pulse, go to next (or shuffled) song
//   prev_button   : pulse, go to previous song
//   mode          : end-of-song policy (STOP / REPEAT_ONE / REPEAT_ALL / SHUFFLE)
//   song_done     : pulse from the song reader at end of song
//   play          : high while playing
//   reset_player  : one-cycle pulse while the FSM sits in SWITCH
//   song          : current song index, always < NUM_SONGS
//   state_dbg     : current FSM state, for observation only
// Interface note: every input is a single-cycle event pulse with no
// back-pressure; an event is consumed in the cycle it is high or dropped.
// When several arrive together the priority is
// song_done > next_button > prev_button > play_button.
module playlist_controller
  import playlist_pkg::*;
#(
  parameter int         NUM_SONGS = 4,
  parameter int         SONG_BITS = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 prev_button,
  input  logic [1:0]           mode,
  input  logic                 song_done,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song,
  output state_t               state_dbg
);

  localparam int                   LAST_I = NUM_SONGS - 1;
  localparam logic [SONG_BITS-1:0] LAST   = LAST_I[SONG_BITS-1:0];
  // One extra bit so NUM_SONGS == 2**SONG_BITS is representable.
  localparam logic [SONG_BITS:0]   NUM_W  = NUM_SONGS[SONG_BITS:0];

  state_t                 state_q, state_d;
  logic [SONG_BITS-1:0]   song_q, song_d;
  logic                   resume_q, resume_d;
  logic                   play_q, reset_player_q;
  logic [7:0]             lfsr_q;

  logic [SONG_BITS-1:0]   song_inc, song_dec;
  logic [SONG_BITS-1:0]   r_raw, r_mod, shuf;
  logic [SONG_BITS-1:0]   next_target;

  lfsr_galois8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Explicit wrap compares keep non-power-of-two playlists in range.
  assign song_inc = (song_q == LAST) ? '0 : song_q + 1'b1;
  assign song_dec = (song_q == '0) ? LAST : song_q - 1'b1;

  // The raw draw is below 2*NUM_SONGS, so one conditional subtract folds it
  // into range. A draw equal to the current song steps forward instead so
  // the same song never repeats back to back.
  assign r_raw = lfsr_q[SONG_BITS-1:0];
  assign r_mod = ({1'b0, r_raw} >= NUM_W) ? (r_raw - NUM_W[SONG_BITS-1:0]) : r_raw;
  assign shuf  = (NUM_SONGS == 1) ? '0 :
                 (r_mod == song_q) ? song_inc : r_mod;

  assign next_target = (mode == MODE_SHUFFLE) ? shuf : song_inc;

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    case (state_q)
      PAUSED: begin
        // song_done has no meaning while paused and is ignored.
        if (next_button) begin
          state_d  = SWITCH;
          song_d   = next_target;
          resume_d = 1'b0;
        end else if (prev_button) begin
          state_d  = SWITCH;
          song_d   = song_dec;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (song_done) begin
          state_d  = SWITCH;
          resume_d = (mode != MODE_STOP);
          case (mode)
            MODE_REPEAT_ONE: song_d = song_q;
            MODE_SHUFFLE:    song_d = shuf;
            default:         song_d = song_inc;
          endcase
        end else if (next_button) begin
          state_d  = SWITCH;
          song_d   = next_target;
          resume_d = 1'b1;
        end else if (prev_button) begin
          state_d  = SWITCH;
          song_d   = song_dec;
          resume_d = 1'b1;
        end else if (play_button) begin
          state_d = PAUSED;
        end
      end
      SWITCH: begin
        state_d = resume_q ? PLAYING : PAUSED;
      end
      default: begin
        state_d = PAUSED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= PAUSED;
      song_q         <= '0;
      resume_q       <= 1'b0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_q         <= song_d;
      resume_q       <= resume_d;
      play_q         <= (state_d == PLAYING);
      reset_player_q <= (state_d == SWITCH);
    end
  end

  assign play         = play_q;
  assign reset_player = reset_player_q;
  assign song         = song_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_playlist_controller.sv
// Directed bench for playlist_controller. Two instances share one stimulus
// stream: a default 4-song player and a 3-song player (non-power-of-two wrap
// and shuffle). Inputs are driven and outputs sampled on the falling edge.
module tb_playlist_controller;

  logic       clk;
  logic       rst_n;
  logic       play_button, next_button, prev_button, song_done;
  logic [1:0] mode;

  logic       play4, rp4, play3, rp3;
  logic [1:0] song4, song3;
  logic [1:0] st4, st3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_lfsr;
  logic [1:0] song_exp, prev_song, r;
  logic [2:0] seen;

  playlist_controller u_dut4 (
    .clk          (clk),
    .reset        (rst_n),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .mode         (mode),
    .song_done    (song_done),
    .play         (play4),
    .reset_player (rp4),
    .song         (song4),
    .state_dbg    (st4)
  );

  playlist_controller #(.NUM_SONGS(3)) u_dut3 (
    .clk          (clk),
    .reset        (rst_n),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .mode         (mode),
    .song_done    (song_done),
    .play         (play3),
    .reset_player (rp3),
    .song         (song3),
    .state_dbg    (st3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shuffle source: 8-bit Galois, taps B8, seed A5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // driver: apply one cycle of events, return at the next falling edge
  task automatic step(input logic pb, input logic nb, input logic vb, input logic sd);
    play_button = pb;
    next_button = nb;
    prev_button = vb;
    song_done   = sd;
    @(negedge clk);
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    song_done   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mode  = 2'b00;
    play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0; song_done = 1'b0;
    @(negedge clk);
    check("rst_play4", play4, 0);
    check("rst_rp4",   rp4,   0);
    check("rst_song4", song4, 0);
    check("rst_state4", st4,  0);
    check("rst_song3", song3, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 2'b00;
    play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0; song_done = 1'b0;

    // ---- play from reset, then shuffle on the 3-song player ----
    do_reset();
    mode = 2'b11;
    step(1, 0, 0, 0);
    check("play_after_btn", play4, 1);
    check("play_song0",     song4, 0);
    check("play_no_rp",     rp4,   0);
    // decision cycle sees lfsr=EA -> r=2, differs from song 0
    step(0, 0, 0, 1);
    check("shuf_first_song", song3, 2);
    check("shuf_first_rp",   rp3,   1);
    check("shuf_first_play", play3, 0);
    step(0, 0, 0, 0);
    check("shuf_first_resume", play3, 1);
    check("shuf_first_rp_off", rp3,   0);
    song_exp = 2'd2;
    seen = 3'b100;
    for (int i = 0; i < 199; i++) begin
      prev_song = song_exp;
      r = m_lfsr[1:0];
      if (r >= 2'd3) r = r - 2'd3;
      if (r == prev_song) r = (prev_song == 2'd2) ? 2'd0 : prev_song + 2'd1;
      song_exp = r;
      step(0, 0, 0, 1);
      check("shuf_song", song3, song_exp);
      check("shuf_no_repeat", (song3 != prev_song) && (song3 < 2'd3), 1);
      if (song3 < 2'd3) seen[song3] = 1'b1;
      step(0, 0, 0, 0);
    end
    check("shuf_all_seen", seen, 3'b111);

    // ---- REPEAT_ALL wrap on 3 songs ----
    do_reset();
    mode = 2'b10;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    check("rall_at2", song3, 2);
    step(0, 0, 0, 1);
    check("rall_wrap_song", song3, 0);
    check("rall_wrap_rp",   rp3,   1);
    check("rall_wrap_play", play3, 0);
    step(0, 0, 0, 0);
    check("rall_resume", play3, 1);
    check("rall_rp_off", rp3,   0);

    // ---- STOP mode ----
    do_reset();
    mode = 2'b00;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    check("stop_at1", song4, 1);
    step(0, 0, 0, 1);
    check("stop_song", song4, 2);
    check("stop_rp",   rp4,   1);
    step(0, 0, 0, 0);
    check("stop_paused", play4, 0);
    check("stop_rp_off", rp4,   0);
    step(0, 0, 0, 0);
    check("stop_stays", play4, 0);
    step(1, 0, 0, 0);
    check("stop_replay", play4, 1);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    check("stop_at3", song4, 3);
    step(0, 0, 0, 1);
    check("stop_last_wrap", song4, 0);
    step(0, 0, 0, 0);
    check("stop_last_park", play4, 0);

    // ---- prev from song 0 while paused ----
    do_reset();
    step(0, 0, 1, 0);
    check("prev_wrap4", song4, 3);
    check("prev_wrap3", song3, 2);
    check("prev_rp",    rp4,   1);
    check("prev_play",  play4, 0);
    step(0, 0, 0, 0);
    check("prev_stay_paused", play4, 0);
    check("prev_rp_off",      rp4,   0);

    // ---- event priority, REPEAT_ONE ----
    do_reset();
    mode = 2'b01;
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    check("prio_song", song4, 0);
    check("prio_rp",   rp4,   1);
    step(0, 0, 0, 0);
    check("prio_play",   play4, 1);
    check("prio_rp_off", rp4,   0);
    step(0, 0, 0, 0);
    check("prio_pb_dropped", play4, 1);
    step(0, 1, 1, 0);
    check("prio_next_over_prev", song4, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("pause", play4, 0);
    step(0, 0, 0, 1);
    check("paused_done_ignored_rp",   rp4,   0);
    check("paused_done_ignored_song", song4, 1);

    // ---- reset asserted during SWITCH ----
    step(0, 1, 0, 0);
    check("sw_entered", rp4, 1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_rp",   rp4,   0);
    check("sw_rst_play", play4, 0);
    check("sw_rst_song", song4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    check("sw_rel_rp",   rp4,   0);
    check("sw_rel_play", play4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
